// File: rtl/burst_mem.sv
// ---------------------------------------------------------------------------
// burst_mem
//   Simple-dual-port feature memory with a burst read engine. The write side
//   is a plain synchronous port. The read side streams `len` consecutive words
//   starting at `base_add` as a valid/ready stream. Addresses wrap modulo
//   DEPTH, not modulo 2**ADDR_W.
//
// Build option:
//   BURST_MEM_RDW_BYPASS_EN  - when defined, a read that collides with a
//                              same-cycle write to the same address returns
//                              the new data (write-first) via a forwarding
//                              register. When undefined the old word is
//                              returned (read-first).
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   w_en, w_add, w_data  write port (out-of-range addresses ignored)
//   start, base_add, len burst request, sampled only while idle
//   busy                 burst in progress
//   done                 one-cycle pulse at burst end (or len==0 request)
//   err                  one-cycle pulse when base_add >= DEPTH
//   r_data, r_valid      output stream
//   r_ready              stream backpressure from the consumer
// ---------------------------------------------------------------------------
module burst_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 90,
  parameter int ADDR_W = 18,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_add,
  input  logic [DATA_W-1:0] w_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_add,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] r_data,
  output logic              r_valid,
  input  logic              r_ready
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADD = ADDR_W'(DEPTH - 1);

  // Storage and its registered read port (not reset: contents survive reset).
  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic [DATA_W-1:0] ram_q;

  state_t            state;
  logic [ADDR_W-1:0] rd_add;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  beats;

  // ram_v marks the word sitting on the RAM output this cycle ("in flight").
  // It is presented directly when the skid buffer is empty, which gives the
  // T+2 first-beat latency; if not taken it drops into the skid buffer.
  logic              ram_v;
  logic [DATA_W-1:0] buf0;   // head of skid buffer
  logic [DATA_W-1:0] buf1;
  logic [1:0]        count;  // entries held in the skid buffer

  logic [1:0]        occ;
  logic              issue;
  logic              hs;
  logic [DATA_W-1:0] mem_out;

  assign occ     = count + {1'b0, ram_v};
  assign issue   = (state == RUN) && (occ < 2'd2) && (issued != len_q);
  assign r_valid = (count != 2'd0) || ram_v;
  assign r_data  = (count != 2'd0) ? buf0 : (ram_v ? mem_out : '0);
  assign hs      = r_valid && r_ready;

  // -------------------------------------------------------------------------
  // RAM: write port and registered read
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_en && (w_add <= LAST_ADD)) begin
      mem[w_add] <= w_data;
    end
    if (issue) begin
      ram_q <= mem[rd_add];
    end
  end

`ifdef BURST_MEM_RDW_BYPASS_EN
  // Forwarding register: rd_add is always < DEPTH, so an address match also
  // implies the write was in range and actually landed.
  logic              fwd_v;
  logic [DATA_W-1:0] fwd_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fwd_v    <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_v <= issue && w_en && (w_add == rd_add);
      if (issue && w_en && (w_add == rd_add)) begin
        fwd_data <= w_data;
      end
    end
  end

  assign mem_out = fwd_v ? fwd_data : ram_q;
`else
  assign mem_out = ram_q;
`endif

  // -------------------------------------------------------------------------
  // Control FSM, read issue, skid buffer
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rd_add <= '0;
      len_q  <= '0;
      issued <= '0;
      beats  <= '0;
      ram_v  <= 1'b0;
      buf0   <= '0;
      buf1   <= '0;
      count  <= 2'd0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      ram_v <= issue;

      if (issue) begin
        issued <= issued + 1'b1;
        rd_add <= (rd_add == LAST_ADD) ? '0 : rd_add + 1'b1;
      end

      // The issue rule keeps count + ram_v <= 2, so count==2 implies !ram_v.
      case (count)
        2'd0: begin
          if (ram_v && !hs) begin
            buf0  <= mem_out;
            count <= 2'd1;
          end
        end
        2'd1: begin
          if (hs) begin
            if (ram_v) buf0 <= mem_out;
            else       count <= 2'd0;
          end else if (ram_v) begin
            buf1  <= mem_out;
            count <= 2'd2;
          end
        end
        default: begin
          if (hs) begin
            buf0  <= buf1;
            count <= 2'd1;
          end
        end
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            if (base_add > LAST_ADD) begin
              err <= 1'b1;
            end else if (len == '0) begin
              done <= 1'b1;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              rd_add <= base_add;
              len_q  <= len;
              issued <= '0;
              beats  <= '0;
            end
          end
        end
        RUN: begin
          if (hs) begin
            beats <= beats + 1'b1;
            if (beats + 1'b1 == len_q) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_mem.sv
// ---------------------------------------------------------------------------
// tb_burst_mem
//   Self-checking bench for burst_mem. A word-array model of the memory
//   produces the expected beat sequence of each burst; a negedge compare
//   process checks every handshake, stream stability and done/err/busy
//   exclusivity. Directed tests add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_burst_mem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 90;
  localparam int ADDR_W = 18;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              w_en;
  logic [ADDR_W-1:0] w_add;
  logic [DATA_W-1:0] w_data;
  logic              start;
  logic [ADDR_W-1:0] base_add;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ready;

  burst_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .LEN_W(LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .w_en(w_en), .w_add(w_add), .w_data(w_data),
    .start(start), .base_add(base_add), .len(len),
    .busy(busy), .done(done), .err(err),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errs  = 0;
  int beat_cnt = 0;
  int done_cnt = 0;
  int err_cnt  = 0;

  logic [DATA_W-1:0] mdl_mem [0:DEPTH-1];
  logic [DATA_W-1:0] exp_q [$];

  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    w_en = 1'b1; w_add = ADDR_W'(a); w_data = d;
    tick();
    w_en = 1'b0;
    if (a < DEPTH) mdl_mem[a] = d;
  endtask

  // Drives start for one cycle; returns in cycle T+1.
  task automatic start_burst(input int b, input int l);
    start = 1'b1; base_add = ADDR_W'(b); len = LEN_W'(l);
    if (b < DEPTH) begin
      for (int i = 0; i < l; i++) exp_q.push_back(mdl_mem[(b + i) % DEPTH]);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, input bit rnd);
    logic [15:0] pat;
    bit got;
    pat = 16'b0100_1110_0101_1001;  // LSB first: 1,0,0,1,1,0,1,0,...
    got = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      r_ready = rnd ? pat[n % 16] : 1'b1;
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    r_ready = 1'b1;
    chk("done_seen", 32'(got), 32'd1);
  endtask

  // Compare process: every cycle the stream is meaningful.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(r_valid), 32'd1);
        chk("stall_data", r_data, prev_data);
      end
      if (done || err) begin
        chk("done_err_excl", 32'(done && err), 32'd0);
        if (done) chk("busy_at_done", 32'(busy), 32'd0);
      end
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (r_valid && r_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else chk("beat_data", r_data, exp_q.pop_front());
      end
      prev_stall = r_valid && !r_ready;
      prev_data  = r_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit          t1_busy  [1:8];
    bit          t1_valid [1:8];
    bit          t1_done  [1:8];
    int          b0, d0, e0;

    t1_busy  = '{1,1,1,1,1,1,0,0};
    t1_valid = '{0,1,1,1,1,1,0,0};
    t1_done  = '{0,0,0,0,0,0,1,0};

    rst_n = 1'b0; w_en = 1'b0; w_add = '0; w_data = '0;
    start = 1'b0; base_add = '0; len = '0; r_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_valid", 32'(r_valid), 32'd0);
    chk("rst_data", r_data, 32'd0);
    rst_n = 1'b1;
    tick();

    // Load memory; out-of-range writes must not alias onto words 0 or 10.
    for (int i = 0; i < DEPTH; i++) wr(i, 32'hA000_0000 + 32'(i));
    wr(90, 32'h1111_1111);
    wr(100, 32'h2222_2222);

    // 1. Basic burst with cycle-exact timing
    start_burst(10, 5);
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("t1_busy_T+%0d", k), 32'(busy), 32'(t1_busy[k]));
      chk($sformatf("t1_valid_T+%0d", k), 32'(r_valid), 32'(t1_valid[k]));
      chk($sformatf("t1_done_T+%0d", k), 32'(done), 32'(t1_done[k]));
      if (k == 2) chk("t1_first", r_data, 32'hA000_000A);
      if (k == 6) chk("t1_last", r_data, 32'hA000_000E);
      tick();
    end
    chk("t1_all_beats", 32'(exp_q.size()), 32'd0);

    // 2. Wrap across DEPTH
    d0 = done_cnt;
    start_burst(87, 6);
    repeat (4) tick();                  // cycle T+5: fourth beat
    chk("t2_wrap_beat", r_data, 32'hA000_0000);
    wait_done(20, 1'b0);
    tick();
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);
    chk("t2_all_beats", 32'(exp_q.size()), 32'd0);

    // 3. Backpressure
    b0 = beat_cnt;
    start_burst(0, 8);
    wait_done(60, 1'b1);
    chk("t3_beat_count", 32'(beat_cnt - b0), 32'd8);
    chk("t3_all_beats", 32'(exp_q.size()), 32'd0);
    tick();

    // 4a. len == 0
    start_burst(5, 0);
    chk("t4_len0_done", 32'(done), 32'd1);
    chk("t4_len0_busy", 32'(busy), 32'd0);
    chk("t4_len0_valid", 32'(r_valid), 32'd0);
    tick();
    chk("t4_len0_done_pulse", 32'(done), 32'd0);

    // 4b. base out of range
    d0 = done_cnt; e0 = err_cnt;
    start_burst(90, 4);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_err_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(err), 32'd0);
    chk("t4_err_busy2", 32'(busy), 32'd0);
    chk("t4_err_count", 32'(err_cnt - e0), 32'd1);
    chk("t4_err_nodone", 32'(done_cnt - d0), 32'd0);

    // 4c. start while busy is ignored
    b0 = beat_cnt;
    start_burst(30, 3);
    start = 1'b1; base_add = ADDR_W'(50); len = LEN_W'(4);
    tick();
    start = 1'b0;
    wait_done(20, 1'b0);
    repeat (3) tick();
    chk("t4_busy_start_beats", 32'(beat_cnt - b0), 32'd3);
    chk("t4_busy_start_idle", 32'(busy), 32'd0);
    chk("t4_busy_start_valid", 32'(r_valid), 32'd0);

    // 5. Read-during-write collision on the second read (address 21)
    start_burst(20, 4);                 // now cycle T+1, first read issued
`ifdef BURST_MEM_RDW_BYPASS_EN
    exp_q[1] = 32'hDEAD_BEEF;
`endif
    tick();                             // cycle T+2: read of 21 issues
    w_en = 1'b1; w_add = ADDR_W'(21); w_data = 32'hDEAD_BEEF;
    mdl_mem[21] = 32'hDEAD_BEEF;
    tick();                             // cycle T+3: beat 2 on the stream
    w_en = 1'b0;
`ifdef BURST_MEM_RDW_BYPASS_EN
    chk("t5_collision", r_data, 32'hDEAD_BEEF);
`else
    chk("t5_collision", r_data, 32'hA000_0015);
`endif
    wait_done(20, 1'b0);
    tick();

    // 6. Reset mid-burst
    d0 = done_cnt;
    start_burst(40, 10);
    repeat (3) tick();                  // cycle T+4: third beat
    chk("t6_third_beat", r_data, 32'hA000_002A);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    chk("t6_valid", 32'(r_valid), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    tick();
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    start_burst(0, 2);
    tick();
    chk("t6_beat0", r_data, 32'hA000_0000);
    tick();
    chk("t6_beat1", r_data, 32'hA000_0001);
    wait_done(10, 1'b0);
    chk("t6_all_beats", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
